// File: rtl/ascon_pack.sv
// ---------------------------------------------------------------------------
// ascon_pack
//   Shared types and constants for the ASCON permutation datapath.
//   - type_state : 320-bit permutation state, five 64-bit words, word 0 = x0
//   - perm_fsm_t : control states of the iterative permutation controller
//   - ROUND_LAST : index of the final round of any permutation (p^a or p^b)
//   - first_round(): first round index for a permutation of a given length
// ---------------------------------------------------------------------------
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perm_fsm_t;

    localparam logic [3:0]  ROUND_LAST  = 4'd11;
    localparam int unsigned ROUND_TOTAL = 12;

    // Shorter permutations run the tail of the 12-round schedule, so they
    // start part-way through and always finish on ROUND_LAST.
    function automatic logic [3:0] first_round(input int unsigned rounds);
        return 4'(ROUND_TOTAL - rounds);
    endfunction

endpackage

// File: rtl/round_counter.sv
// ---------------------------------------------------------------------------
// round_counter
//   Round index register for the iterative permutation.
//   Ports:
//     clock_i       in   rising-edge clock
//     reset_i       in   synchronous active-high reset (index -> 0)
//     clear_i       in   synchronous clear (index -> 0), used on abort
//     load_i        in   load load_value_i (start of a permutation)
//     load_value_i  in   first round index
//     enable_i      in   advance one round; holds once ROUND_LAST is reached
//     round_o       out  current round index, never above ROUND_LAST
//     last_o        out  round_o == ROUND_LAST
// ---------------------------------------------------------------------------
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [3:0] load_value_i,
    input  logic       enable_i,
    output logic [3:0] round_o,
    output logic       last_o
);

    logic [3:0] round_q;

    // NOTE: clocked state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock_i) begin
        if (reset_i || clear_i) begin
            round_q <= '0;
        end else if (load_i) begin
            round_q <= load_value_i;
        end else if (enable_i && (round_q != ROUND_LAST)) begin
            round_q <= round_q + 4'd1;
        end
    end

    assign round_o = round_q;
    assign last_o  = (round_q == ROUND_LAST);

endmodule

// File: rtl/perm_round_ctrl.sv
// ---------------------------------------------------------------------------
// perm_round_ctrl
//   Iterative ASCON permutation controller and state register. The state
//   register closes the loop around the external round datapath + xor_end:
//   state_o -> round(round_o) -> xor_end -> state_feedback_i -> state_o.
//   Runs p^a (ROUNDS_A rounds) or p^b (ROUNDS_B rounds), always ending on
//   round 11, and handshakes with the mode FSM through start_i / done_o.
//
//   Optional build macro: PERM_ABORT_EN adds abort_i, which cancels a running
//   permutation (state and round cleared, no done_o pulse).
//
//   Ports:
//     clock_i           in   rising-edge clock
//     reset_i           in   synchronous active-high reset
//     start_i           in   start request, only honoured in IDLE
//     mode_rounds_i     in   0: p^a, 1: p^b (sampled with start_i)
//     end_xor_en_i      in   apply xor_end on the last round (sampled with start_i)
//     end_xor_key_i     in   1: key XOR, 0: domain-bit XOR (sampled with start_i)
//     abort_i           in   (PERM_ABORT_EN only) cancel the running permutation
//     state_init_i      in   initial state, loaded on start
//     state_feedback_i  in   xor_end output for the current state_o / round_o
//     round_o           out  current round index to constant addition
//     bypass_xor_end_o  out  to xor_end bypass_xor_end_i
//     mode_xor_key_o    out  to xor_end mode_xor_key_i
//     state_o           out  registered permutation state
//     busy_o            out  high while rounds are being applied
//     done_o            out  one-cycle pulse, state_o holds the result
// ---------------------------------------------------------------------------
module perm_round_ctrl
    import ascon_pack::*;
#(
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       mode_rounds_i,
    input  logic       end_xor_en_i,
    input  logic       end_xor_key_i,
`ifdef PERM_ABORT_EN
    input  logic       abort_i,
`endif
    input  type_state  state_init_i,
    input  type_state  state_feedback_i,
    output logic [3:0] round_o,
    output logic       bypass_xor_end_o,
    output logic       mode_xor_key_o,
    output type_state  state_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [3:0] FIRST_A = first_round(ROUNDS_A);
    localparam logic [3:0] FIRST_B = first_round(ROUNDS_B);

    perm_fsm_t fsm_q, fsm_d;
    type_state state_q;
    logic      end_xor_en_q;
    logic      end_xor_key_q;

    logic      start_accept;
    logic      round_step;
    logic      abort_hit;
    logic      abort_req;
    logic      round_last;

`ifdef PERM_ABORT_EN
    assign abort_req = abort_i;
`else
    assign abort_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        fsm_d        = fsm_q;
        start_accept = 1'b0;
        round_step   = 1'b0;
        abort_hit    = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    fsm_d        = RUN;
                    start_accept = 1'b1;
                end
            end
            RUN: begin
                // Abort wins over round progression, including on round 11.
                if (abort_req) begin
                    fsm_d     = IDLE;
                    abort_hit = 1'b1;
                end else begin
                    round_step = 1'b1;
                    if (round_last) begin
                        fsm_d = DONE;
                    end
                end
            end
            DONE: begin
                // start_i is deliberately not looked at here: no queuing.
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM, permutation state and latched per-permutation options
    // ------------------------------------------------------------------
    // NOTE: the 320-bit state register is reset on purpose: downstream logic
    // treats state_o == 0 after reset or abort as a defined value, and partial
    // state from an interrupted permutation must not leak out.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q         <= IDLE;
            state_q       <= '0;
            end_xor_en_q  <= 1'b0;
            end_xor_key_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            if (start_accept) begin
                state_q       <= state_init_i;
                end_xor_en_q  <= end_xor_en_i;
                end_xor_key_q <= end_xor_key_i;
            end else if (abort_hit) begin
                state_q <= '0;
            end else if (round_step) begin
                state_q <= state_feedback_i;
            end
        end
    end

    round_counter u_round_counter (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .clear_i      (abort_hit),
        .load_i       (start_accept),
        .load_value_i (mode_rounds_i ? FIRST_B : FIRST_A),
        .enable_i     (round_step),
        .round_o      (round_o),
        .last_o       (round_last)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign state_o = state_q;
    assign busy_o  = (fsm_q == RUN);
    assign done_o  = (fsm_q == DONE);

    // xor_end is only live on the final round of a permutation that asked for it.
    assign bypass_xor_end_o = !(busy_o && round_last && end_xor_en_q);
    assign mode_xor_key_o   = busy_o && end_xor_key_q;

endmodule

// File: tb/tb_perm_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_perm_round_ctrl
//   Closed-loop bench: the ASCON round function and xor_end are modelled here
//   and fed back into the controller; expected final states are computed by
//   iterating the same round model and queued when each permutation starts.
// ---------------------------------------------------------------------------
module tb_perm_round_ctrl;
    import ascon_pack::*;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic       mode_rounds_i;
    logic       end_xor_en_i;
    logic       end_xor_key_i;
`ifdef PERM_ABORT_EN
    logic       abort_i;
`endif
    type_state  state_init_i;
    type_state  state_feedback_i;
    logic [3:0] round_o;
    logic       bypass_xor_end_o;
    logic       mode_xor_key_o;
    type_state  state_o;
    logic       busy_o;
    logic       done_o;

    int errors = 0;
    int checks = 0;
    type_state exp_q[$];

    localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] NONCE = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [63:0]  IV    = 64'h80400c0600000000;

    always #5 clock_i = ~clock_i;

    perm_round_ctrl dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .mode_rounds_i    (mode_rounds_i),
        .end_xor_en_i     (end_xor_en_i),
        .end_xor_key_i    (end_xor_key_i),
`ifdef PERM_ABORT_EN
        .abort_i          (abort_i),
`endif
        .state_init_i     (state_init_i),
        .state_feedback_i (state_feedback_i),
        .round_o          (round_o),
        .bypass_xor_end_o (bypass_xor_end_o),
        .mode_xor_key_o   (mode_xor_key_o),
        .state_o          (state_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    // ---------------- reference models ----------------
    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic type_state ascon_round(input type_state s_in, input logic [3:0] r);
        type_state s_out;
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s_in[0]; x1 = s_in[1]; x2 = s_in[2]; x3 = s_in[3]; x4 = s_in[4];
        x2 = x2 ^ {56'd0, 4'd15 - r, r};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        s_out[0] = x0; s_out[1] = x1; s_out[2] = x2; s_out[3] = x3; s_out[4] = x4;
        return s_out;
    endfunction

    function automatic type_state xor_end(input type_state s, input logic bypass, input logic key_mode);
        type_state r;
        r = s;
        if (!bypass) begin
            if (key_mode) begin
                r[3] = r[3] ^ KEY[127:64];
                r[4] = r[4] ^ KEY[63:0];
            end else begin
                r[4] = r[4] ^ 64'd1;
            end
        end
        return r;
    endfunction

    function automatic type_state model_perm(input type_state init, input int first,
                                             input logic en, input logic key);
        type_state s;
        s = init;
        for (int r = first; r <= 11; r++) begin
            s = ascon_round(s, 4'(r));
            if (r == 11 && en) s = xor_end(s, 1'b0, key);
        end
        return s;
    endfunction

    // Round chain closing the loop around the DUT.
    always_comb state_feedback_i = xor_end(ascon_round(state_o, round_o),
                                           bypass_xor_end_o, mode_xor_key_o);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " state_o"}, state_o, '0);
        check({tag, " round_o"}, 320'(round_o), 320'(0));
        check({tag, " busy_o"}, 320'(busy_o), 320'(0));
        check({tag, " done_o"}, 320'(done_o), 320'(0));
        check({tag, " bypass"}, 320'(bypass_xor_end_o), 320'(1));
        check({tag, " key_mode"}, 320'(mode_xor_key_o), 320'(0));
    endtask

    // Called on the negedge right after the start edge; returns on the DONE cycle.
    task automatic watch_perm(input string tag, input int first, input int rounds,
                              input logic en, input logic key, input logic toggle_mode);
        int k;
        logic [3:0] exp_round;
        type_state exp_s;
        k = 0;
        while (!done_o && k < 30) begin
            exp_round = 4'(first + k);
            check({tag, " busy"}, 320'(busy_o), 320'(1));
            check({tag, " round"}, 320'(round_o), 320'(exp_round));
            check({tag, " bypass"}, 320'(bypass_xor_end_o),
                  320'(!(en && exp_round == 4'd11)));
            check({tag, " key_mode"}, 320'(mode_xor_key_o), 320'(key));
            if (toggle_mode) mode_rounds_i = ~mode_rounds_i;
            k++;
            @(negedge clock_i);
        end
        check({tag, " latency"}, 320'(k), 320'(rounds));
        check({tag, " done"}, 320'(done_o), 320'(1));
        check({tag, " busy in done"}, 320'(busy_o), 320'(0));
        check({tag, " key_mode in done"}, 320'(mode_xor_key_o), 320'(0));
        check({tag, " round saturated"}, 320'(round_o), 320'(11));
        check({tag, " scoreboard depth"}, 320'(exp_q.size()), 320'(1));
        if (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            check({tag, " state"}, state_o, exp_s);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        type_state iv_vec, vec_b, vec_c, held;

        iv_vec = {NONCE[63:0], NONCE[127:64], KEY[63:0], KEY[127:64], IV};
        vec_b  = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
                  64'hdeadbeefcafef00d, 64'h1122334455667788};
        vec_c  = {64'ha5a5a5a5a5a5a5a5, 64'h5a5a5a5a5a5a5a5a, 64'h0000000000000001,
                  64'hffffffffffffffff, 64'h8000000000000000};

        reset_i = 1'b1; start_i = 1'b0; mode_rounds_i = 1'b0;
        end_xor_en_i = 1'b0; end_xor_key_i = 1'b0; state_init_i = '0;
`ifdef PERM_ABORT_EN
        abort_i = 1'b0;
`endif
        repeat (2) @(negedge clock_i);
        check_reset_values("por");
        reset_i = 1'b0;

        // Reset held two cycles in the middle of a p^a run.
        state_init_i = iv_vec; start_i = 1'b1; mode_rounds_i = 1'b0;
        end_xor_en_i = 1'b1; end_xor_key_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        check("midrst started", 320'(busy_o), 320'(1));
        repeat (4) @(negedge clock_i);
        reset_i = 1'b1;
        repeat (2) @(negedge clock_i);
        check_reset_values("midrst");
        reset_i = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock_i);
            check("midrst quiet", {busy_o, done_o, round_o}, '0);
        end
        check("midrst state", state_o, '0);

        // p^a on IV||K||N, domain-bit xor_end; option inputs change after start.
        exp_q.push_back(model_perm(iv_vec, 0, 1'b1, 1'b0));
        state_init_i = iv_vec; start_i = 1'b1; mode_rounds_i = 1'b0;
        end_xor_en_i = 1'b1; end_xor_key_i = 1'b0;
        @(negedge clock_i);
        start_i = 1'b0; end_xor_en_i = 1'b0; end_xor_key_i = 1'b1; mode_rounds_i = 1'b1;
        watch_perm("pa", 0, 12, 1'b1, 1'b0, 1'b0);
        held = model_perm(iv_vec, 0, 1'b1, 1'b0);
        repeat (3) @(negedge clock_i);
        check("pa idle done", 320'(done_o), 320'(0));
        check("pa state hold", state_o, held);

        // p^b with key xor_end.
        exp_q.push_back(model_perm(vec_b, 6, 1'b1, 1'b1));
        state_init_i = vec_b; start_i = 1'b1; mode_rounds_i = 1'b1;
        end_xor_en_i = 1'b1; end_xor_key_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        watch_perm("pb", 6, 6, 1'b1, 1'b1, 1'b0);
        @(negedge clock_i);

        // xor_end disabled: bare p^a, bypass stays 1 even on round 11.
        exp_q.push_back(model_perm(iv_vec, 0, 1'b0, 1'b1));
        state_init_i = iv_vec; start_i = 1'b1; mode_rounds_i = 1'b0;
        end_xor_en_i = 1'b0; end_xor_key_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        watch_perm("pa bare", 0, 12, 1'b0, 1'b1, 1'b0);
        @(negedge clock_i);

        // start_i held high through RUN and DONE, mode_rounds_i toggling in RUN.
        exp_q.push_back(model_perm(vec_c, 0, 1'b0, 1'b0));
        state_init_i = vec_c; start_i = 1'b1; mode_rounds_i = 1'b0;
        end_xor_en_i = 1'b0; end_xor_key_i = 1'b0;
        @(negedge clock_i);
        watch_perm("hold", 0, 12, 1'b0, 1'b0, 1'b1);
        // DONE cycle with start_i still high: next cycle must be IDLE.
        mode_rounds_i = 1'b1; end_xor_en_i = 1'b1; end_xor_key_i = 1'b1;
        state_init_i = vec_b;
        @(negedge clock_i);
        check("hold idle", {busy_o, done_o}, '0);
        exp_q.push_back(model_perm(vec_b, 6, 1'b1, 1'b1));
        @(negedge clock_i);
        start_i = 1'b0;
        watch_perm("restart", 6, 6, 1'b1, 1'b1, 1'b0);
        @(negedge clock_i);

`ifdef PERM_ABORT_EN
        // Abort at round 5 of a p^a run.
        state_init_i = iv_vec; start_i = 1'b1; mode_rounds_i = 1'b0;
        end_xor_en_i = 1'b1; end_xor_key_i = 1'b0;
        @(negedge clock_i);
        start_i = 1'b0;
        repeat (5) @(negedge clock_i);
        check("abort at round", 320'(round_o), 320'(5));
        abort_i = 1'b1;
        @(negedge clock_i);
        abort_i = 1'b0;
        check_reset_values("abort");
        for (int i = 0; i < 12; i++) begin
            @(negedge clock_i);
            check("abort no done", {busy_o, done_o}, '0);
        end
`endif

        check("scoreboard drained", 320'(exp_q.size()), 320'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
